// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter: default latency, requester limit
// and the per-stage ownership tag carried alongside each in-flight multiply.
package mul_pkg;
    localparam int MUL_LAT_DEF = 2;
    localparam int NREQ_MAX    = 8;
    localparam int IDX_W       = $clog2(NREQ_MAX);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
// Reports the one-hot grant, its index and the pointer to use after this grant.
module rr_arb #(
    parameter int  NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            hit,
    output logic [PW-1:0]   nxt_ptr
);
    int k;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        hit     = 1'b0;
        nxt_ptr = ptr;
        k       = 0;
        for (int off = 0; off < NREQ; off++) begin
            k = (int'(ptr) + off) % NREQ;
            if (en && !hit && req[k]) begin
                hit     = 1'b1;
                gnt[k]  = 1'b1;
                idx     = PW'(k);
                nxt_ptr = PW'((k + 1) % NREQ);
            end
        end
    end
endmodule

// File: rtl/mul_arb.sv
// Shares one pipelined multiplier among NREQ requesters: round-robin issue,
// an ownership tag pipeline matching the multiplier latency, and response routing.
module mul_arb
    import mul_pkg::*;
#(
    parameter int  NBITS   = 128,
    parameter int  NREQ    = 4,
    parameter int  MUL_LAT = MUL_LAT_DEF,
    localparam int PW      = $clog2(NREQ),
    localparam int CW      = $clog2(MUL_LAT + 2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][NBITS-1:0] req_a,
    input  logic [NREQ-1:0][NBITS-1:0] req_b,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [2*NBITS-1:0]         rsp_y,
    output logic                       mul_en,
    output logic [NBITS-1:0]           mul_a,
    output logic [NBITS-1:0]           mul_b,
    input  logic                       mul_done,
    input  logic [2*NBITS-1:0]         mul_y,
    output logic [CW-1:0]              inflight,
    output logic                       err,
    input  logic                       err_clr
);
    logic [PW-1:0]        ptr, nxt_ptr, gnt_idx;
    logic                 hit;
    tag_t [MUL_LAT:0]     tag_q;
    tag_t                 fin;
    logic [2*NBITS-1:0]   rsp_y_q;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .en      (arb_en & rst_n),
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .idx     (gnt_idx),
        .hit     (hit),
        .nxt_ptr (nxt_ptr)
    );

    assign fin = tag_q[MUL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            mul_en   <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            tag_q    <= '0;
            inflight <= '0;
            err      <= 1'b0;
            rsp_y_q  <= '0;
        end else begin
            mul_en <= hit;
            if (hit) begin
                mul_a <= req_a[gnt_idx];
                mul_b <= req_b[gnt_idx];
                ptr   <= nxt_ptr;
            end
            // The multiplier never stalls, so tags advance every cycle.
            tag_q[0].valid <= hit;
            tag_q[0].idx   <= IDX_W'(gnt_idx);
            for (int s = 1; s <= MUL_LAT; s++)
                tag_q[s] <= tag_q[s-1];
            if (hit && !fin.valid)
                inflight <= inflight + CW'(1);
            else if (!hit && fin.valid)
                inflight <= inflight - CW'(1);
            if (mul_done != fin.valid)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
            if (fin.valid)
                rsp_y_q <= mul_y;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (fin.valid)
            rsp_valid[fin.idx[PW-1:0]] = 1'b1;
        rsp_y = fin.valid ? mul_y : rsp_y_q;
    end
endmodule

// File: tb/tb_mul_arb.sv
// Randomized and directed stimulus for mul_arb with a queue scoreboard; a small
// latency-2 multiplier model sits on the multiplier side of the DUT.
module tb_mul_arb;
    localparam int NBITS = 128;
    localparam int NREQ  = 4;
    localparam int LAT   = 2;
    localparam int CW    = $clog2(LAT + 2);

    logic                       clk, rst_n, arb_en, err_clr, force_done;
    logic [NREQ-1:0]            req, gnt, rsp_valid;
    logic [NREQ-1:0][NBITS-1:0] req_a, req_b;
    logic [2*NBITS-1:0]         rsp_y, mul_y;
    logic                       mul_en, mul_done, err;
    logic [NBITS-1:0]           mul_a, mul_b;
    logic [CW-1:0]              inflight;

    mul_arb #(.NBITS(NBITS), .NREQ(NREQ), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .mul_en(mul_en), .mul_a(mul_a),
        .mul_b(mul_b), .mul_done(mul_done), .mul_y(mul_y), .inflight(inflight), .err(err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product and done appear LAT cycles after a sampled enable.
    logic [1:0]         m_v;
    logic [2*NBITS-1:0] m_p0, m_p1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v  <= '0;
            m_p0 <= '0;
            m_p1 <= '0;
        end else begin
            m_v  <= {m_v[0], mul_en};
            m_p0 <= {{NBITS{1'b0}}, mul_a} * {{NBITS{1'b0}}, mul_b};
            m_p1 <= m_p0;
        end
    end
    assign mul_done = m_v[1] | force_done;
    assign mul_y    = m_p1;

    typedef struct {
        int                 idx;
        logic [2*NBITS-1:0] y;
        int                 issue;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   err_exp = 1'b0;

    task automatic chk(input string name, input logic [2*NBITS-1:0] act, input logic [2*NBITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stimulus side: reference grant decision and expected product pushed at grant time.
    initial begin : issue_model
        int  ptr_m;
        bit  prev_g;
        int  gi;
        ptr_m  = 0;
        prev_g = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ptr_m  = 0;
                prev_g = 1'b0;
            end else begin
                gi = -1;
                if (arb_en)
                    for (int k = 0; k < NREQ; k++)
                        if (gi < 0 && req[(ptr_m + k) % NREQ]) gi = (ptr_m + k) % NREQ;
                chk("gnt", gnt, (gi >= 0) ? (256'(1) << gi) : '0);
                chk("mul_en", mul_en, prev_g);
                if (gi >= 0) begin
                    q.push_back('{gi, {{NBITS{1'b0}}, req_a[gi]} * {{NBITS{1'b0}}, req_b[gi]}, cyc});
                    ptr_m = (gi + 1) % NREQ;
                end
                prev_g = (gi >= 0);
            end
        end
    end

    // Monitor: pops expectations when due and checks responses, occupancy and err.
    initial begin : monitor
        int   n;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", gnt, '0);
                chk("rst_rsp_valid", rsp_valid, '0);
                chk("rst_rsp_y", rsp_y, '0);
                chk("rst_mul_en", mul_en, '0);
                chk("rst_mul_a", mul_a, '0);
                chk("rst_mul_b", mul_b, '0);
                chk("rst_inflight", inflight, '0);
                chk("rst_err", err, '0);
                q.delete();
            end else begin
                n = 0;
                foreach (q[i]) if (q[i].issue < cyc) n++;
                chk("inflight", inflight, n);
                chk("err", err, err_exp);
                if (q.size() > 0 && q[0].issue + 1 + LAT == cyc) begin
                    e = q.pop_front();
                    chk("rsp_valid", rsp_valid, 256'(1) << e.idx);
                    chk("rsp_y", rsp_y, e.y);
                end else begin
                    chk("rsp_idle", rsp_valid, '0);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [NBITS-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [2*NBITS-1:0] max_sq;
        max_sq = {{(NBITS-1){1'b1}}, 1'b0, {(NBITS-1){1'b0}}, 1'b1};
        rst_n = 1'b1; arb_en = 1'b0; req = '0; err_clr = 1'b0; force_done = 1'b0;
        req_a = '0; req_b = '0;
        #2 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;

        // Full contention from ptr=0, requester 0 squares 2^127.
        arb_en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            req_a = {rnd(), rnd(), rnd(), 128'h8000_0000_0000_0000_0000_0000_0000_0000};
            req_b = {rnd(), rnd(), rnd(), 128'h8000_0000_0000_0000_0000_0000_0000_0000};
            step(1);
        end
        req = '0; step(4);

        // Grants withheld while disabled, then 0 and 2 alternate.
        arb_en = 1'b0; req = 4'b0101; step(3);
        arb_en = 1'b1; step(2);
        req = '0; step(4);

        // Single op 3*5 from requester 1.
        req_a[1] = 128'd3; req_b[1] = 128'd5; req = 4'b0010; step(1);
        req = '0; step(3);
        chk("single_y", rsp_y, 256'd15);

        req = 4'b0001; step(5);
        req = '0; step(4);

        // Largest operands from requester 3.
        req_a[3] = '1; req_b[3] = '1; req = 4'b1000; step(1);
        req = '0; step(3);
        chk("max_y", rsp_y, max_sq);

        // Reset with two ops in flight; afterwards the pointer restarts at 0.
        req = 4'b1111; step(2);
        rst_n = 1'b0; req = '0; step(2);
        rst_n = 1'b1; step(5);
        req = 4'b1111; step(1);
        req = '0; step(4);

        // Spurious done with an empty pipeline, then clear; mismatch beats clear.
        arb_en = 1'b0; step(2);
        force_done = 1'b1; step(1);
        force_done = 1'b0; err_exp = 1'b1; step(3);
        err_clr = 1'b1; step(1);
        err_clr = 1'b0; err_exp = 1'b0; step(2);
        force_done = 1'b1; err_clr = 1'b1; step(1);
        force_done = 1'b0; err_clr = 1'b0; err_exp = 1'b1; step(2);
        err_clr = 1'b1; step(1);
        err_clr = 1'b0; err_exp = 1'b0; step(2);

        for (int i = 0; i < 400; i++) begin
            req    = NREQ'($urandom_range(0, 15));
            arb_en = ($urandom_range(0, 9) != 0);
            for (int r = 0; r < NREQ; r++) begin
                req_a[r] = rnd();
                req_b[r] = rnd();
            end
            step(1);
        end
        req = '0; step(6);

        chk("drain", 256'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined NBITS x NBITS integer multiplier among NREQ requesters.
- Accepts operand pairs from requesters and issues at most one multiply per cycle through a registered issue stage.
- Tracks the owner of every in-flight operation with a tag pipeline and routes each 2*NBITS product back to that owner.
- Sits between the compute engines and the shared multiplier: it drives the multiplier's enable/operand inputs and consumes its done/product outputs.

Parameters:
- NBITS, 128, operand width; product is 2*NBITS.
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, multiplier latency in cycles from sampled enable to done/product.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  when 0, no new grants; in-flight ops still complete.
- req  in  NREQ  per-requester request level; held until granted.
- req_a  in  NREQ*NBITS  operand a; slice i belongs to requester i.
- req_b  in  NREQ*NBITS  operand b; slice i belongs to requester i.
- gnt  out  NREQ  one-hot; acceptance pulse in the cycle operands are taken.
- rsp_valid  out  NREQ  one-hot one-cycle pulse; product is for that requester.
- rsp_y  out  2*NBITS  product, shared bus; valid only with rsp_valid.
- mul_en  out  1  registered enable pulse to the multiplier.
- mul_a  out  NBITS  registered operand a to the multiplier.
- mul_b  out  NBITS  registered operand b to the multiplier.
- mul_done  in  1  multiplier done pulse.
- mul_y  in  2*NBITS  multiplier product.
- inflight  out  clog2(MUL_LAT+2)  number of issued ops without a response.
- err  out  1  sticky tag/done mismatch flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_y=0, mul_en=0, mul_a=0, mul_b=0, inflight=0, err=0. Round-robin pointer resets to 0 and the tag pipeline resets to all-invalid.
- Grant: combinational. In cycle t, if arb_en=1 and req!=0, grant the first requester with req=1, searching from ptr upward with wrap. At most one gnt bit is set.
- Pointer: after a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue: at the edge ending cycle t with gnt[i]=1, mul_en<=1, mul_a<=req_a[i], mul_b<=req_b[i], and tag stage 0 <= {valid=1, idx=i}. With no grant, mul_en<=0, tag stage 0 is invalid, and mul_a/mul_b hold their values.
- Tag pipeline: MUL_LAT+1 stages, shifting every cycle (the multiplier cannot stall).
- Response: when the final tag stage is valid with idx=k, rsp_valid[k]=1 and rsp_y=mul_y, both combinational from the current cycle. rsp_y holds its last value otherwise.
- Latency: gnt in cycle t gives rsp_valid in cycle t+1+MUL_LAT (t+3 by default). Throughput is 1 op/cycle; back-to-back grants produce back-to-back responses in grant order.
- Requester obligation: after gnt, a requester that wants another op keeps req high with new operands. Requesters must accept rsp_valid unconditionally; there is no backpressure.
- Mismatch: if mul_done differs from the final-stage tag valid bit, err<=1 (sticky). If err_clr is asserted in the same cycle as a new mismatch, the mismatch wins.
- inflight: +1 on issue, -1 on response, unchanged when both happen in the same cycle.
- arb_en deasserted: gnt=0 from that cycle onward; ops already in the pipeline still respond.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. The multiplier shares rst_n.
- Single requester held continuously: granted every cycle.
- All requesters held: grants rotate i, i+1, ... with wrap, one grant per cycle.

Decomposition:
- Shared package mul_pkg holds MUL_LAT_DEF=2, a tag typedef {valid, idx[clog2(NREQ)-1:0]}, and an NREQ_MAX constant.
- One sub-module: rr_arb (NREQ-wide round-robin arbiter: req, ptr -> one-hot gnt and next ptr), reusable by other shared units.
- The tag pipeline and issue registers stay in mul_arb.

Test Plan:
- Single op: req[1]=1, a=3, b=5 at t. Expect gnt=4'b0010 at t; mul_en at t+1; rsp_valid=4'b0010 and rsp_y=15 at t+3; inflight goes 1 then 0.
- Full contention: req=4'b1111 held 8 cycles with ptr=0. Expect gnt sequence 1,2,4,8,1,2,4,8. Responses arrive in the same order 3 cycles later, each with that requester's product, e.g. a=b=2^127 gives 2^254.
- arb_en=0 while req=4'b0101. Expect no gnt and no mul_en; re-enable gives grant to requester 0, then requester 2.
- Reset mid-flight: assert rst_n=0 one cycle after two grants. Expect all outputs 0, no rsp_valid after release, ptr=0.
- Mismatch: force mul_done=1 with the tag pipeline empty. Expect err=1 stays set; err_clr=1 for one cycle clears it.
- Max operands: a=b=2^128-1 from requester 3. Expect rsp_y=2^256-2^129+1 and rsp_valid=4'b1000.
